load_store_unit: RTL and testbench

//   Multicycle load/store sequencer between the core's memory stage and data_memory_interface.

---
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer: accepts one request, issues word-aligned read beats or lane-positioned write beats, returns one response.
// Build option MISALIGNED_SPLIT_EN: when defined, misaligned accesses are split into beats; otherwise they fault.
`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h0000_1000
`endif
`ifndef DATA_END
`define DATA_END 32'h0000_1FFF
`endif

module load_store_unit #(
    parameter logic [31:0] RANGE_BEGIN = `DATA_BEGIN,
    parameter logic [31:0] RANGE_END   = `DATA_END
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_format,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [2:0]  mem_data_format,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    state_t state_q, state_d;

    logic        write_q;
    logic [2:0]  fmt_q;
    logic [31:0] addr_q, wdata_q, word0_q, rdata_q;
    logic [1:0]  beat_q, last_beat_q;
    logic        fault_q;

    logic [2:0]  req_size;
    logic [32:0] req_last;
    logic        req_cross, req_fault;
    logic [1:0]  req_last_beat;
`ifndef MISALIGNED_SPLIT_EN
    logic        req_misaligned;
`endif

    always_comb begin
        req_size  = (req_format[1:0] == 2'b00) ? 3'd0 : (req_format[1:0] == 2'b01) ? 3'd1 : 3'd3;
        req_last  = {1'b0, req_address} + {30'b0, req_size};
        req_cross = ({1'b0, req_address[1:0]} + req_size) > 3'd3;
        req_fault = (req_format[1:0] == 2'b11) || (req_address < RANGE_BEGIN) ||
                    req_last[32] || (req_last[31:0] > RANGE_END);
`ifndef MISALIGNED_SPLIT_EN
        req_misaligned = ((req_format[1:0] == 2'b01) && req_address[0]) ||
                         ((req_format[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
        req_fault = req_fault || req_misaligned;
`endif
        // Loads always fetch whole words, so a crossing load is two beats; a store with a
        // three-byte remainder needs a half plus a byte in the next word.
        if (!req_cross)                req_last_beat = 2'd0;
        else if (!req_write)           req_last_beat = 2'd1;
        else if (req_last[1:0] == 2'd2) req_last_beat = 2'd2;
        else                           req_last_beat = 2'd1;
    end

    logic [31:0] word_addr, next_addr, rem_data, w0, w1, shifted, ext;
    logic [1:0]  rem_last;

    always_comb begin
        word_addr = {addr_q[31:2], 2'b00};
        next_addr = word_addr + 32'd4;
        rem_data  = wdata_q >> {3'd4 - {1'b0, addr_q[1:0]}, 3'b000};
        rem_last  = addr_q[1:0] + ((fmt_q[1:0] == 2'b00) ? 2'd0 : (fmt_q[1:0] == 2'b01) ? 2'd1 : 2'd3);
        w0        = (last_beat_q == 2'd1) ? word0_q : mem_read_data;
        w1        = (last_beat_q == 2'd1) ? mem_read_data : 32'h0;
        shifted   = 32'({w1, w0} >> {addr_q[1:0], 3'b000});
        case (fmt_q[1:0])
            2'b00:   ext = fmt_q[2] ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ext = fmt_q[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = req_fault ? S_RESP : S_ISSUE;
            S_ISSUE: if (beat_q == last_beat_q) state_d = write_q ? S_RESP : S_WAIT;
            S_WAIT:  state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q     <= 1'b0;
            fmt_q       <= 3'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            word0_q     <= 32'h0;
            rdata_q     <= 32'h0;
            beat_q      <= 2'd0;
            last_beat_q <= 2'd0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    write_q     <= req_write;
                    fmt_q       <= req_format;
                    addr_q      <= req_address;
                    wdata_q     <= req_wdata;
                    beat_q      <= 2'd0;
                    last_beat_q <= req_last_beat;
                    if (req_fault) begin
                        rdata_q <= 32'h0;
                        fault_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    beat_q <= beat_q + 2'd1;
                    if (!write_q && beat_q == 2'd1) word0_q <= mem_read_data;
                    if (write_q && beat_q == last_beat_q) begin
                        rdata_q <= 32'h0;
                        fault_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    rdata_q <= ext;
                    fault_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready        = (state_q == S_IDLE);
        resp_valid       = (state_q == S_RESP);
        resp_rdata       = rdata_q;
        resp_fault       = fault_q;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_data_format  = 3'b000;
        mem_address      = 32'h0;
        mem_write_data   = 32'h0;
        if (state_q == S_ISSUE) begin
            if (!write_q) begin
                mem_read_enable = 1'b1;
                mem_data_format = 3'b010;
                mem_address     = (beat_q == 2'd0) ? word_addr : next_addr;
            end else begin
                mem_write_enable = 1'b1;
                case (beat_q)
                    2'd0: begin
                        mem_data_format = {1'b0, fmt_q[1:0]};
                        mem_address     = addr_q;
                        mem_write_data  = wdata_q << {addr_q[1:0], 3'b000};
                    end
                    2'd1: begin
                        mem_data_format = (last_beat_q == 2'd2 || rem_last != 2'd0) ? 3'b001 : 3'b000;
                        mem_address     = next_addr;
                        mem_write_data  = rem_data;
                    end
                    default: begin
                        mem_data_format = 3'b000;
                        mem_address     = next_addr + 32'd2;
                        mem_write_data  = {8'h0, rem_data[23:16], 16'h0};
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-word byte-enabled memory model behind the mem_* port.
module tb_load_store_unit;
    localparam logic [31:0] RB = 32'h0000_1000;
    localparam logic [31:0] RE = 32'h0000_1FFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_format = 3'b0;
    logic [31:0] req_address = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_read_enable, mem_write_enable;
    logic [2:0]  mem_data_format;
    logic [31:0] mem_address, mem_write_data;
    logic [31:0] mem_read_data = 32'h0;

    always #5 clock = ~clock;

    load_store_unit #(.RANGE_BEGIN(RB), .RANGE_END(RE)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_format(req_format), .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_data_format(mem_data_format), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    logic [31:0] mem [16];
    logic [3:0]  be;
    initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    always @(posedge clock) begin
        if (mem_write_enable) begin
            be = 4'((mem_data_format[1:0] == 2'b00 ? 4'b0001 :
                     mem_data_format[1:0] == 2'b01 ? 4'b0011 : 4'b1111) << mem_address[1:0]);
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[mem_address[5:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
        end
        if (mem_read_enable) mem_read_data <= mem[mem_address[5:2]];
    end

    typedef struct {
        logic        we;
        logic [2:0]  fmt;
        logic [31:0] addr;
        logic [31:0] dat;
    } beat_t;
    beat_t beats[$];
    int resp_cnt = 0, dual_cnt = 0;

    always @(negedge clock) begin
        if (mem_read_enable || mem_write_enable)
            beats.push_back('{mem_write_enable, mem_data_format, mem_address, mem_write_data});
        if (mem_read_enable && mem_write_enable) dual_cnt++;
        if (resp_valid) resp_cnt++;
    end

    int checks = 0, errors = 0, n_req = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_req(input logic wr, input logic [2:0] fmt, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                           output int lat);
        beats.delete();
        @(negedge clock);
        req_valid = 1'b1; req_write = wr; req_format = fmt; req_address = addr; req_wdata = wd;
        @(posedge clock); #1;
        req_valid = 1'b0; req_address = 32'h0; req_wdata = 32'h0; req_format = 3'b0;
        n_req++;
        lat = 0;
        while (lat < 20) begin
            @(negedge clock);
            lat++;
            if (resp_valid) break;
        end
        if (!resp_valid) lat = 99;
        rd  = resp_rdata;
        flt = resp_fault;
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  fmt;
        logic [31:0] addr, wd, rd;
        logic        flt;
        int          lat, nb;
        logic [2:0]  bfmt;
        logic [31:0] baddr, bdat;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic wr, input logic [2:0] fmt, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input logic flt,
                                input int lat, input int nb, input logic [2:0] bfmt,
                                input logic [31:0] baddr, input logic [31:0] bdat);
        vecs.push_back('{wr, fmt, addr, wd, rd, flt, lat, nb, bfmt, baddr, bdat});
    endfunction

    logic [31:0] rd;
    logic        flt;
    int          lat;

    initial begin
        //  wr fmt     addr          wdata          rdata          flt lat nb beat-fmt beat-addr      beat-data
        add(1, 3'b010, 32'h1000, 32'hDEADBEEF, 32'h00000000, 0, 2, 1, 3'b010, 32'h1000, 32'hDEADBEEF);
        add(0, 3'b010, 32'h1000, 32'h0,        32'hDEADBEEF, 0, 3, 1, 3'b010, 32'h1000, 32'h0);
        add(1, 3'b010, 32'h1004, 32'h80FF0000, 32'h00000000, 0, 2, 1, 3'b010, 32'h1004, 32'h80FF0000);
        add(0, 3'b000, 32'h1007, 32'h0,        32'hFFFFFF80, 0, 3, 1, 3'b010, 32'h1004, 32'h0);
        add(0, 3'b100, 32'h1007, 32'h0,        32'h00000080, 0, 3, 1, 3'b010, 32'h1004, 32'h0);
        add(1, 3'b001, 32'h1006, 32'h0000ABCD, 32'h00000000, 0, 2, 1, 3'b001, 32'h1006, 32'hABCD0000);
        add(0, 3'b001, 32'h1006, 32'h0,        32'hFFFFABCD, 0, 3, 1, 3'b010, 32'h1004, 32'h0);
        add(0, 3'b101, 32'h1006, 32'h0,        32'h0000ABCD, 0, 3, 1, 3'b010, 32'h1004, 32'h0);
        add(0, 3'b000, 32'h1006, 32'h0,        32'hFFFFFFCD, 0, 3, 1, 3'b010, 32'h1004, 32'h0);
        add(1, 3'b000, 32'h1005, 32'h12345677, 32'h00000000, 0, 2, 1, 3'b000, 32'h1005, 32'h34567700);
        add(0, 3'b010, 32'h1004, 32'h0,        32'hABCD7700, 0, 3, 1, 3'b010, 32'h1004, 32'h0);
        add(1, 3'b000, 32'h1FFF, 32'h0000005A, 32'h00000000, 0, 2, 1, 3'b000, 32'h1FFF, 32'h5A000000);
        add(0, 3'b100, 32'h1FFF, 32'h0,        32'h0000005A, 0, 3, 1, 3'b010, 32'h1FFC, 32'h0);
        add(0, 3'b011, 32'h1000, 32'h0,        32'h00000000, 1, 1, 0, 3'b000, 32'h0,    32'h0);
        add(0, 3'b010, 32'h0FFC, 32'h0,        32'h00000000, 1, 1, 0, 3'b000, 32'h0,    32'h0);
        add(0, 3'b000, 32'h2000, 32'h0,        32'h00000000, 1, 1, 0, 3'b000, 32'h0,    32'h0);
        add(1, 3'b010, 32'h1FFE, 32'h11111111, 32'h00000000, 1, 1, 0, 3'b000, 32'h0,    32'h0);
        add(0, 3'b001, 32'hFFFFFFFF, 32'h0,    32'h00000000, 1, 1, 0, 3'b000, 32'h0,    32'h0);
        add(0, 3'b010, 32'h1FFC, 32'h0,        32'h5A000000, 0, 3, 1, 3'b010, 32'h1FFC, 32'h0);
`ifdef MISALIGNED_SPLIT_EN
        add(0, 3'b001, 32'h1005, 32'h0,        32'hFFFFCD77, 0, 3, 1, 3'b010, 32'h1004, 32'h0);
        add(1, 3'b010, 32'h1009, 32'h11223344, 32'h00000000, 0, 3, 2, 3'b010, 32'h1009, 32'h22334400);
        add(0, 3'b010, 32'h1009, 32'h0,        32'h11223344, 0, 4, 2, 3'b010, 32'h1008, 32'h0);
        add(1, 3'b001, 32'h1017, 32'h0000BEEF, 32'h00000000, 0, 3, 2, 3'b001, 32'h1017, 32'hEF000000);
        add(0, 3'b101, 32'h1017, 32'h0,        32'h0000BEEF, 0, 4, 2, 3'b010, 32'h1014, 32'h0);
`else
        add(0, 3'b001, 32'h1001, 32'h0,        32'h00000000, 1, 1, 0, 3'b000, 32'h0,    32'h0);
        add(1, 3'b010, 32'h1002, 32'h55555555, 32'h00000000, 1, 1, 0, 3'b000, 32'h0,    32'h0);
`endif

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'h0);
        chk("reset_resp_fault", {31'b0, resp_fault}, 32'd0);
        chk("reset_enables", {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
        chk("reset_mem_address", mem_address, 32'h0);
        chk("reset_mem_write_data", mem_write_data, 32'h0);

        foreach (vecs[i]) begin
            run_req(vecs[i].wr, vecs[i].fmt, vecs[i].addr, vecs[i].wd, rd, flt, lat);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
            chk($sformatf("v%0d_fault", i), {31'b0, flt}, {31'b0, vecs[i].flt});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_beats", i), beats.size(), vecs[i].nb);
            if (vecs[i].nb > 0 && beats.size() > 0) begin
                chk($sformatf("v%0d_beat0_we", i), {31'b0, beats[0].we}, {31'b0, vecs[i].wr});
                chk($sformatf("v%0d_beat0_fmt", i), {29'b0, beats[0].fmt}, {29'b0, vecs[i].bfmt});
                chk($sformatf("v%0d_beat0_addr", i), beats[0].addr, vecs[i].baddr);
                if (vecs[i].wr) chk($sformatf("v%0d_beat0_data", i), beats[0].dat, vecs[i].bdat);
            end
        end

`ifdef MISALIGNED_SPLIT_EN
        // Word store three bytes short of a boundary: word piece, half at next+0, byte at next+2.
        run_req(1, 3'b010, 32'h1013, 32'hA1B2C3D4, rd, flt, lat);
        chk("split3_latency", lat, 32'd4);
        chk("split3_beats", beats.size(), 32'd3);
        if (beats.size() == 3) begin
            chk("split3_b0", {beats[0].fmt, beats[0].addr[28:0]}, {3'b010, 29'h1013});
            chk("split3_b0_data", beats[0].dat, 32'hD4000000);
            chk("split3_b1", {beats[1].fmt, beats[1].addr[28:0]}, {3'b001, 29'h1014});
            chk("split3_b1_data", beats[1].dat & 32'h0000FFFF, 32'h0000B2C3);
            chk("split3_b2", {beats[2].fmt, beats[2].addr[28:0]}, {3'b000, 29'h1016});
            chk("split3_b2_data", beats[2].dat & 32'h00FF0000, 32'h00A10000);
        end
        run_req(0, 3'b010, 32'h1013, 32'h0, rd, flt, lat);
        chk("split3_load_rdata", rd, 32'hA1B2C3D4);
        chk("split3_load_latency", lat, 32'd4);
`endif

        // Reset in the middle of a store: enables must drop immediately and no response follows.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_format = 3'b010; req_wdata = 32'hCAFEF00D;
`ifdef MISALIGNED_SPLIT_EN
        req_address = 32'h1023;
`else
        req_address = 32'h1020;
`endif
        @(posedge clock); #1;
        req_valid = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        @(posedge clock); #1;
        chk("abort_beat_addr", mem_address, 32'h1024);
`else
        chk("abort_beat_addr", mem_address, 32'h1020);
`endif
        chk("abort_we_before", {31'b0, mem_write_enable}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_enables", {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("abort_no_resp", resp_cnt, n_req);
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);

        run_req(0, 3'b010, 32'h1000, 32'h0, rd, flt, lat);
        chk("recover_rdata", rd, 32'hDEADBEEF);
        chk("recover_latency", lat, 32'd3);
        @(negedge clock);
        chk("resp_pulse_count", resp_cnt, n_req);
        chk("dual_enable_cycles", dual_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
